// File: rtl/usb_key_fifo_pkg.sv
// usb_key_fifo_pkg
//   Definitions shared by the keystroke FIFO and the scancode converter:
//   register addresses, STATUS/control bit positions, the HID modifier masks
//   and the packed FIFO entry layout.
package usb_key_fifo_pkg;

  // Register map seen from the Z80 bus
  localparam logic [7:0] USB_KF_STATUS = 8'h00;
  localparam logic [7:0] USB_KF_CHAR   = 8'h01;
  localparam logic [7:0] USB_KF_MOD    = 8'h02;
  localparam logic [7:0] USB_KF_COUNT  = 8'h03;

  // STATUS read bits
  localparam int STAT_NEMPTY_BIT = 0;
  localparam int STAT_FULL_BIT   = 1;
  localparam int STAT_OVF_BIT    = 2;

  // STATUS write (control) bits
  localparam int CTRL_OVFCLR_BIT = 0;
  localparam int CTRL_FLUSH_BIT  = 7;

  // HID modifier byte: left/right shift and left/right ctrl
  localparam logic [7:0] SHIFT_MASK = 8'h22;
  localparam logic [7:0] CTRL_MASK  = 8'h11;

  // One FIFO entry: modifier byte in the upper half, ASCII in the lower
  typedef struct packed {
    logic [7:0] mod;
    logic [7:0] chr;
  } key_entry_t;

endpackage

// File: rtl/usb_key_fifo_ram.sv
// sync_fifo_ram
//   Storage array for the keystroke FIFO: one synchronous write port and one
//   asynchronous read port. No reset; the FIFO control decides what is valid.
//   Ports:
//     clk_i   clock
//     we_i    write enable
//     waddr_i write address
//     wdata_i write data
//     raddr_i read address
//     rdata_o read data (combinational from raddr_i)
module sync_fifo_ram #(
  parameter int AW = 4,
  parameter int DW = 16
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/usb_key_fifo.sv
// usb_key_fifo
//   Keystroke buffer between the USB HID keyboard path and the Z80 register
//   bus. Every accepted key strobe stores {modifier, ascii}; the CPU drains
//   entries by reading the CHAR register at its own pace.
//   Ports:
//     clk_i        CPU clock (only clock)
//     rst_n_i      synchronous reset, active low
//     key_valid_i  one-cycle new-key strobe
//     key_char_i   ASCII code, valid with key_valid_i
//     key_mod_i    HID modifier byte, valid with key_valid_i
//     usb_cs       register chip select (may be held for several cycles)
//     wr_n         0 = write access, 1 = read access
//     reg_addr_i   register address
//     data_i       write data
//     data_o       read data, combinational decode of registered state
//     irq_o        registered, high while the FIFO holds at least one key
//
//   Transfer semantics: the key side is a plain strobe with no backpressure;
//   a key arriving while the FIFO is full (and nothing pops that cycle) is
//   dropped and the sticky ovf flag records it. On the bus side one read
//   access to CHAR (usb_cs & wr_n & addr==CHAR, however many cycles long)
//   pops exactly one entry, at the first cycle of the access.
module usb_key_fifo
  import usb_key_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter bit DROP_NULL  = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       key_valid_i,
  input  logic [7:0] key_char_i,
  input  logic [7:0] key_mod_i,
  input  logic       usb_cs,
  input  logic       wr_n,
  input  logic [7:0] reg_addr_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       irq_o
);

  localparam logic [DEPTH_LOG2:0]   FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [DEPTH_LOG2-1:0] rptr_q, wptr_q;
  logic [DEPTH_LOG2:0]   count_q, count_nxt;
  logic                  ovf_q;
  logic                  irq_q;
  logic                  rd01_q;
  logic [7:0]            char_hold_q;

  logic       empty, full;
  logic       rd01, pop_req, hold_active;
  logic       st_wr, flush, ovf_clr;
  logic       key_kept, pop_ok, push_ok, ovf_set;
  logic [15:0] head_raw;
  key_entry_t  head, wentry;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  // Bus decode. The pop is the rising edge of the CHAR read select so a
  // long chip-select pulse still removes only one key.
  assign rd01        = usb_cs & wr_n & (reg_addr_i == USB_KF_CHAR);
  assign pop_req     = rd01 & ~rd01_q;
  assign hold_active = rd01 & rd01_q;

  assign st_wr   = usb_cs & ~wr_n & (reg_addr_i == USB_KF_STATUS);
  assign flush   = st_wr & data_i[CTRL_FLUSH_BIT];
  assign ovf_clr = st_wr & data_i[CTRL_OVFCLR_BIT];

  // A null char comes from an unmapped scancode and carries no keystroke.
  assign key_kept = key_valid_i & ~(DROP_NULL & (key_char_i == 8'h00));

  // Flush overrides both sides. A pop frees a slot in the same cycle, so a
  // push into a full FIFO is still accepted when it coincides with a pop.
  assign pop_ok  = pop_req & ~empty & ~flush;
  assign push_ok = key_kept & (~full | pop_ok) & ~flush;
  assign ovf_set = key_kept & full & ~pop_ok & ~flush;

  assign wentry.mod = key_mod_i;
  assign wentry.chr = key_char_i;

  sync_fifo_ram #(
    .AW (DEPTH_LOG2),
    .DW ($bits(key_entry_t))
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (push_ok),
    .waddr_i (wptr_q),
    .wdata_i (wentry),
    .raddr_i (rptr_q),
    .rdata_o (head_raw)
  );

  assign head = key_entry_t'(head_raw);

  always_comb begin
    count_nxt = count_q;
    if (flush) begin
      count_nxt = '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   count_nxt = count_q + CNT_ONE;
        2'b01:   count_nxt = count_q - CNT_ONE;
        default: count_nxt = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rptr_q      <= '0;
      wptr_q      <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      irq_q       <= 1'b0;
      rd01_q      <= 1'b0;
      char_hold_q <= 8'h00;
    end else begin
      rd01_q  <= rd01;
      count_q <= count_nxt;
      irq_q   <= (count_nxt != '0);

      if (flush) begin
        rptr_q <= '0;
        wptr_q <= '0;
      end else begin
        if (pop_ok)  rptr_q <= rptr_q + PTR_ONE;
        if (push_ok) wptr_q <= wptr_q + PTR_ONE;
      end

      // Set beats clear when both land in one cycle; flush clears outright.
      if (flush)        ovf_q <= 1'b0;
      else if (ovf_set) ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;

      // Remember the head being popped so the rest of the access keeps
      // showing it even though rptr has already advanced.
      if (pop_req) char_hold_q <= empty ? 8'h00 : head.chr;
    end
  end

  always_comb begin
    data_o = 8'h00;
    case (reg_addr_i)
      USB_KF_STATUS: begin
        data_o[STAT_OVF_BIT]    = ovf_q;
        data_o[STAT_FULL_BIT]   = full;
        data_o[STAT_NEMPTY_BIT] = ~empty;
      end
      USB_KF_CHAR: begin
        if (hold_active)  data_o = char_hold_q;
        else if (!empty)  data_o = head.chr;
      end
      USB_KF_MOD: begin
        if (!empty) data_o = head.mod;
      end
      USB_KF_COUNT: data_o = 8'(count_q);
      default:      data_o = 8'h00;
    endcase
  end

  assign irq_o = irq_q;

endmodule

// File: tb/tb_usb_key_fifo.sv
// tb_usb_key_fifo
//   Directed bench for usb_key_fifo: reset state, ordered draining, the
//   single-pop-per-access rule, overflow, simultaneous push/pop when full,
//   null filtering, flush with a colliding push, and reset mid-operation.
module tb_usb_key_fifo;

  logic       clk_i;
  logic       rst_n_i;
  logic       key_valid_i;
  logic [7:0] key_char_i;
  logic [7:0] key_mod_i;
  logic       usb_cs;
  logic       wr_n;
  logic [7:0] reg_addr_i;
  logic [7:0] data_i;
  logic [7:0] data_o;
  logic       irq_o;

  int checks = 0;
  int errors = 0;

  usb_key_fifo dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .key_valid_i (key_valid_i),
    .key_char_i  (key_char_i),
    .key_mod_i   (key_mod_i),
    .usb_cs      (usb_cs),
    .wr_n        (wr_n),
    .reg_addr_i  (reg_addr_i),
    .data_i      (data_i),
    .data_o      (data_o),
    .irq_o       (irq_o)
  );

  // Clock and reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Checker
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Driver tasks. Inputs change 1 time unit after the rising edge and
  // outputs are sampled 1 unit later, well away from the next edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic bus_read(input logic [7:0] addr, output logic [7:0] d);
    usb_cs = 1'b1; wr_n = 1'b1; reg_addr_i = addr;
    #1 d = data_o;
    tick();
    usb_cs = 1'b0;
    tick();
  endtask

  task automatic bus_write(input logic [7:0] addr, input logic [7:0] d);
    usb_cs = 1'b1; wr_n = 1'b0; reg_addr_i = addr; data_i = d;
    tick();
    usb_cs = 1'b0; wr_n = 1'b1;
    tick();
  endtask

  task automatic push_key(input logic [7:0] ch, input logic [7:0] md);
    key_valid_i = 1'b1; key_char_i = ch; key_mod_i = md;
    tick();
    key_valid_i = 1'b0;
  endtask

  logic [7:0] rd;

  initial begin
    rst_n_i = 1'b0; key_valid_i = 1'b0; key_char_i = 8'h00; key_mod_i = 8'h00;
    usb_cs = 1'b0; wr_n = 1'b1; reg_addr_i = 8'h00; data_i = 8'h00;
    #1;
    repeat (3) tick();
    rst_n_i = 1'b1;
    tick();

    // 1. Reset state
    check("rst_irq", {7'd0, irq_o}, 8'h00);
    bus_read(8'h00, rd); check("rst_status", rd, 8'h00);
    bus_read(8'h03, rd); check("rst_count", rd, 8'h00);
    bus_read(8'h01, rd); check("rst_char_empty", rd, 8'h00);
    bus_read(8'h03, rd); check("rst_count_after_pop", rd, 8'h00);
    bus_read(8'h02, rd); check("rst_mod_empty", rd, 8'h00);

    // 2. Ordered push and drain
    push_key(8'h61, 8'h00);
    check("irq_latency1", {7'd0, irq_o}, 8'h01);
    push_key(8'h42, 8'h02);
    push_key(8'h31, 8'h00);
    tick();
    bus_read(8'h03, rd); check("count3", rd, 8'h03);
    bus_read(8'h02, rd); check("mod_a", rd, 8'h00);
    bus_read(8'h01, rd); check("char_a", rd, 8'h61);
    bus_read(8'h02, rd); check("mod_B", rd, 8'h02);
    bus_read(8'h01, rd); check("char_B", rd, 8'h42);
    bus_read(8'h01, rd); check("char_1", rd, 8'h31);
    bus_read(8'h00, rd); check("status_drained", rd, 8'h00);
    check("irq_drained", {7'd0, irq_o}, 8'h00);

    // 3. Long chip select pops once and holds the old head
    push_key(8'h78, 8'h00);
    push_key(8'h79, 8'h00);
    usb_cs = 1'b1; wr_n = 1'b1; reg_addr_i = 8'h01;
    for (int i = 0; i < 5; i++) begin
      #1 check("hold_char", data_o, 8'h78);
      tick();
    end
    usb_cs = 1'b0;
    tick();
    bus_read(8'h03, rd); check("hold_one_pop", rd, 8'h01);
    bus_read(8'h01, rd); check("hold_next", rd, 8'h79);

    // 4. Overflow: 17 keys into 16 slots
    for (int i = 0; i < 17; i++) push_key(8'h41 + 8'(i), 8'h00);
    tick();
    bus_read(8'h03, rd); check("ovf_count16", rd, 8'h10);
    bus_read(8'h00, rd); check("ovf_status", rd, 8'h07);
    bus_write(8'h00, 8'h01);
    bus_read(8'h00, rd); check("ovf_cleared", rd, 8'h03);
    bus_read(8'h01, rd); check("ovf_first_key", rd, 8'h41);
    bus_read(8'h00, rd); check("after_pop_status", rd, 8'h01);

    // 5. Full, then push and pop edge in the same cycle
    push_key(8'h51, 8'h00);
    tick();
    bus_read(8'h00, rd); check("refull_status", rd, 8'h03);
    usb_cs = 1'b1; wr_n = 1'b1; reg_addr_i = 8'h01;
    key_valid_i = 1'b1; key_char_i = 8'h70; key_mod_i = 8'h00;
    #1 check("full_pushpop_head", data_o, 8'h42);
    tick();
    key_valid_i = 1'b0; usb_cs = 1'b0;
    tick();
    bus_read(8'h03, rd); check("full_pushpop_count", rd, 8'h10);
    bus_read(8'h00, rd); check("full_pushpop_status", rd, 8'h03);
    for (int i = 0; i < 15; i++) begin
      bus_read(8'h01, rd); check("drain", rd, 8'h43 + 8'(i));
    end
    bus_read(8'h01, rd); check("drain_tail", rd, 8'h70);
    bus_read(8'h03, rd); check("drain_count", rd, 8'h00);

    // 6a. Null char discarded
    push_key(8'h00, 8'h01);
    tick();
    check("null_irq", {7'd0, irq_o}, 8'h00);
    bus_read(8'h03, rd); check("null_count", rd, 8'h00);

    // 6b. Flush with a colliding push
    for (int i = 0; i < 5; i++) push_key(8'h30 + 8'(i), 8'h00);
    tick();
    bus_read(8'h03, rd); check("pre_flush_count", rd, 8'h05);
    usb_cs = 1'b1; wr_n = 1'b0; reg_addr_i = 8'h00; data_i = 8'h80;
    key_valid_i = 1'b1; key_char_i = 8'h39;
    tick();
    usb_cs = 1'b0; wr_n = 1'b1; key_valid_i = 1'b0;
    check("flush_irq", {7'd0, irq_o}, 8'h00);
    tick();
    bus_read(8'h03, rd); check("flush_count", rd, 8'h00);
    bus_read(8'h01, rd); check("flush_char", rd, 8'h00);

    // 6c. Reset mid-operation
    for (int i = 0; i < 7; i++) push_key(8'h61 + 8'(i), 8'h00);
    tick();
    bus_read(8'h03, rd); check("pre_rst_count", rd, 8'h07);
    rst_n_i = 1'b0;
    tick();
    rst_n_i = 1'b1;
    check("mid_rst_irq", {7'd0, irq_o}, 8'h00);
    bus_read(8'h00, rd); check("mid_rst_status", rd, 8'h00);
    bus_read(8'h03, rd); check("mid_rst_count", rd, 8'h00);
    push_key(8'h5a, 8'h00);
    tick();
    bus_read(8'h01, rd); check("post_rst_ptr0", rd, 8'h5a);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
